// File: rtl/net_cmd_ingress_pkg.sv
// Shared types for the network command ingress block: command codes, core state,
// queued entry layout and the default FIFO depth.
package net_cmd_ingress_pkg;

    localparam int unsigned DefaultDepth = 4;

    typedef enum logic [2:0] {
        CmdNop     = 3'd0,
        CmdImemWr  = 3'd1,
        CmdRegWr   = 3'd2,
        CmdPcWr    = 3'd3,
        CmdPcWrRun = 3'd4
    } net_cmd_e;

    typedef enum logic [1:0] {
        StateRun  = 2'd0,
        StateIdle = 2'd1,
        StateErr  = 2'd2
    } state_e;

    typedef struct packed {
        net_cmd_e    cmd;
        logic [9:0]  addr;
        logic [31:0] data;
    } net_entry_t;

    function automatic logic cmd_legal(logic [2:0] code);
        return code <= 3'd4;
    endfunction

endpackage

// File: rtl/net_cmd_ingress_if.sv
// Network packet channel: valid/ready handshake carrying command, address, data, parity.
interface net_cmd_ingress_if;

    logic        net_valid_i;
    logic [2:0]  net_cmd_i;
    logic [9:0]  net_addr_i;
    logic [31:0] net_data_i;
    logic        net_parity_i;
    logic        net_ready_o;

    modport master (
        output net_valid_i, net_cmd_i, net_addr_i, net_data_i, net_parity_i,
        input  net_ready_o
    );

    modport slave (
        input  net_valid_i, net_cmd_i, net_addr_i, net_data_i, net_parity_i,
        output net_ready_o
    );

endinterface

// File: rtl/net_cmd_fifo.sv
// Command FIFO with valid/ready push, pop strobe and full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module net_cmd_fifo
    import net_cmd_ingress_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       push_valid,
    output logic       push_ready,
    input  net_entry_t push_entry,
    input  logic       pop,
    output net_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    net_entry_t  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        push;

    assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty      = (wptr_q == rptr_q);
    assign push_ready = ~full;
    // A full FIFO refuses a push even in a cycle that pops.
    assign push       = push_valid & ~full;
    assign head       = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= push_entry;
        end
    end

endmodule

// File: rtl/net_cmd_ingress.sv
// Network command ingress: queues legal packets and issues them as write strobes when the
// core is not running. Optional parity check enabled by the NET_CMD_PARITY_EN macro.
module net_cmd_ingress
    import net_cmd_ingress_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth
) (
    input  logic                 clk,
    input  logic                 n_reset,
    net_cmd_ingress_if.slave     net,
    input  state_e               state_i,
    input  logic                 stall_i,
    output logic                 imem_we_o,
    output logic                 reg_we_o,
    output logic [9:0]           addr_o,
    output logic [31:0]          data_o,
    output logic                 pc_we_o,
    output logic                 net_PC_write_cmd_IDLE_o,
    output logic [7:0]           drop_cnt_o
);

    net_entry_t push_entry, head;
    logic       fifo_push_ready, fifo_full, fifo_empty;
    logic       accept, pkt_ok, issue;
    logic [7:0] drop_cnt_q, drop_cnt_d;

`ifdef NET_CMD_PARITY_EN
    assign pkt_ok = cmd_legal(net.net_cmd_i) &
                    ~(^{net.net_cmd_i, net.net_addr_i, net.net_data_i, net.net_parity_i});
`else
    logic unused_parity;
    assign unused_parity = net.net_parity_i;
    assign pkt_ok        = cmd_legal(net.net_cmd_i);
`endif

    // Ready is gated by reset so every output reads 0 while n_reset is low.
    assign net.net_ready_o = n_reset & ~fifo_full;
    assign accept          = net.net_valid_i & fifo_push_ready & n_reset;
    assign push_entry      = '{cmd:  net_cmd_e'(net.net_cmd_i),
                               addr: net.net_addr_i,
                               data: net.net_data_i};
    assign issue           = ~fifo_empty & ~stall_i & (state_i != StateRun);

    net_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .n_reset    (n_reset),
        .push_valid (accept & pkt_ok),
        .push_ready (fifo_push_ready),
        .push_entry (push_entry),
        .pop        (issue),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && !pkt_ok && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;

    always_comb begin
        imem_we_o               = 1'b0;
        reg_we_o                = 1'b0;
        pc_we_o                 = 1'b0;
        net_PC_write_cmd_IDLE_o = 1'b0;
        addr_o                  = '0;
        data_o                  = '0;
        if (issue) begin
            addr_o = head.addr;
            data_o = head.data;
            case (head.cmd)
                CmdImemWr:  imem_we_o = 1'b1;
                CmdRegWr:   reg_we_o  = 1'b1;
                CmdPcWr:    pc_we_o   = 1'b1;
                CmdPcWrRun: begin
                    pc_we_o                 = 1'b1;
                    net_PC_write_cmd_IDLE_o = (state_i == StateIdle);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_net_cmd_ingress.sv
// Self-checking bench for net_cmd_ingress: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_net_cmd_ingress;
    import net_cmd_ingress_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        n_reset;
    state_e      state;
    logic        stall;
    logic        imem_we, reg_we, pc_we, pc_rel;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [7:0]  drop_cnt;

    int total  = 0;
    int passed = 0;

    net_cmd_ingress_if net_if ();

    net_cmd_ingress #(
        .DEPTH (DEPTH)
    ) dut (
        .clk                     (clk),
        .n_reset                 (n_reset),
        .net                     (net_if),
        .state_i                 (state),
        .stall_i                 (stall),
        .imem_we_o               (imem_we),
        .reg_we_o                (reg_we),
        .addr_o                  (addr),
        .data_o                  (data),
        .pc_we_o                 (pc_we),
        .net_PC_write_cmd_IDLE_o (pc_rel),
        .drop_cnt_o              (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of accepted packets and a saturating drop count.
    typedef struct {
        logic [2:0]  cmd;
        logic [9:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   mdrop = 0;

    function automatic bit model_ok(logic [2:0] c, logic [9:0] a, logic [31:0] d, logic p);
        bit ok;
        ok = (c <= 3'd4);
`ifdef NET_CMD_PARITY_EN
        if ((^{c, a, d, p}) != 1'b0) ok = 1'b0;
`else
        if (p === 1'bx) ok = 1'b0;
`endif
        return ok;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) begin
                mq.delete();
                mdrop = 0;
            end else begin
                bit rdy, iss;
                rdy = (mq.size() < DEPTH);
                iss = (mq.size() > 0) && !stall && (state != StateRun);
                if (iss) mq.delete(0);
                if (net_if.net_valid_i && rdy) begin
                    if (model_ok(net_if.net_cmd_i, net_if.net_addr_i, net_if.net_data_i,
                                 net_if.net_parity_i)) begin
                        mq.push_back('{cmd: net_if.net_cmd_i, addr: net_if.net_addr_i,
                                       data: net_if.net_data_i});
                    end else if (mdrop < 255) begin
                        mdrop++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            logic [54:0] act, exp;
            logic        e_rdy, e_imem, e_reg, e_pc, e_rel;
            logic [9:0]  e_addr;
            logic [31:0] e_data;
            @(negedge clk);
            {e_rdy, e_imem, e_reg, e_pc, e_rel} = '0;
            e_addr = '0;
            e_data = '0;
            if (n_reset) begin
                e_rdy = (mq.size() < DEPTH);
                if (mq.size() > 0 && !stall && state != StateRun) begin
                    e_addr = mq[0].addr;
                    e_data = mq[0].data;
                    e_imem = (mq[0].cmd == 3'd1);
                    e_reg  = (mq[0].cmd == 3'd2);
                    e_pc   = (mq[0].cmd == 3'd3) || (mq[0].cmd == 3'd4);
                    e_rel  = (mq[0].cmd == 3'd4) && (state == StateIdle);
                end
            end
            exp = {e_rdy, e_imem, e_reg, e_pc, e_rel, e_addr, e_data,
                   n_reset ? 8'(mdrop) : 8'd0};
            act = {net_if.net_ready_o, imem_we, reg_we, pc_we, pc_rel, addr, data, drop_cnt};
            total++;
            if (act === exp) passed++;
            else $display("FAIL cycle t=%0t: got %h expected %h", $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one packet for one cycle; returns just after the accepting edge.
    task automatic send(input logic [2:0] c, input logic [9:0] a, input logic [31:0] d,
                        input bit bad_par);
        step();
        net_if.net_valid_i  = 1'b1;
        net_if.net_cmd_i    = c;
        net_if.net_addr_i   = a;
        net_if.net_data_i   = d;
        net_if.net_parity_i = (^{c, a, d}) ^ bad_par;
        step();
        net_if.net_valid_i  = 1'b0;
    endtask

    initial begin
        n_reset             = 1'b0;
        state               = StateIdle;
        stall               = 1'b0;
        net_if.net_valid_i  = 1'b0;
        net_if.net_cmd_i    = '0;
        net_if.net_addr_i   = '0;
        net_if.net_data_i   = '0;
        net_if.net_parity_i = 1'b0;

        #12;
        chk("reset_ready", 64'(net_if.net_ready_o), 64'd0);
        step();
        n_reset = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(net_if.net_ready_o), 64'd1);
        chk("release_drop", 64'(drop_cnt), 64'd0);

        // IMEM write from IDLE.
        send(3'd1, 10'h010, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk("imem_we", 64'(imem_we), 64'd1);
        chk("imem_addr", 64'(addr), 64'h010);
        chk("imem_data", 64'(data), 64'hDEADBEEF);
        chk("imem_other", 64'({reg_we, pc_we, pc_rel}), 64'd0);

        // Hold while running, then drain in order (pointers wrap).
        step();
        state = StateRun;
        for (int i = 0; i < 4; i++) send(3'd2, 10'(i), 32'h11111111 * i, 1'b0);
        @(negedge clk);
        chk("run_full_ready", 64'(net_if.net_ready_o), 64'd0);
        chk("run_no_strobe", 64'(reg_we), 64'd0);
        step();
        state = StateIdle;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_we", 64'(reg_we), 64'd1);
            chk("drain_addr", 64'(addr), 64'(i));
            if (i == 0) chk("full_dequeue_ready", 64'(net_if.net_ready_o), 64'd0);
        end
        @(negedge clk);
        chk("drain_done", 64'(reg_we), 64'd0);

        // PC release from IDLE, then from ERR.
        send(3'd4, 10'h000, 32'h00000040, 1'b0);
        @(negedge clk);
        chk("rel_pc_we", 64'(pc_we), 64'd1);
        chk("rel_pulse", 64'(pc_rel), 64'd1);
        chk("rel_data", 64'(data), 64'h40);
        @(negedge clk);
        chk("rel_one_cycle", 64'({pc_we, pc_rel}), 64'd0);
        step();
        state = StateErr;
        send(3'd4, 10'h000, 32'h00000040, 1'b0);
        @(negedge clk);
        chk("err_pc_we", 64'(pc_we), 64'd1);
        chk("err_no_pulse", 64'(pc_rel), 64'd0);

        // Drops: illegal codes, then optional parity failure, then saturation.
        step();
        state = StateIdle;
        for (int i = 0; i < 3; i++) send(3'd6, 10'h3FF, 32'h0, 1'b0);
        @(negedge clk);
        chk("drop_three", 64'(drop_cnt), 64'd3);
        send(3'd2, 10'h005, 32'h00001234, 1'b1);
        @(negedge clk);
`ifdef NET_CMD_PARITY_EN
        chk("parity_drop", 64'(drop_cnt), 64'd4);
        chk("parity_no_strobe", 64'(reg_we), 64'd0);
`else
        chk("parity_ignored_drop", 64'(drop_cnt), 64'd3);
        chk("parity_ignored_we", 64'(reg_we), 64'd1);
`endif
        step();
        net_if.net_valid_i = 1'b1;
        net_if.net_cmd_i   = 3'd7;
        repeat (300) step();
        net_if.net_valid_i = 1'b0;
        @(negedge clk);
        chk("drop_saturate", 64'(drop_cnt), 64'd255);

        // Stall holds the queue; reset mid-stream discards it.
        step();
        stall = 1'b1;
        send(3'd2, 10'h021, 32'hA5A5A5A5, 1'b0);
        send(3'd1, 10'h022, 32'h5A5A5A5A, 1'b0);
        @(negedge clk);
        chk("stall_no_issue", 64'({imem_we, reg_we}), 64'd0);
        chk("stall_ready", 64'(net_if.net_ready_o), 64'd1);
        step();
        n_reset = 1'b0;
        #1;
        chk("reset_outputs", 64'({net_if.net_ready_o, imem_we, reg_we, pc_we, pc_rel, addr,
                                  data, drop_cnt}), 64'd0);
        stall = 1'b0;
        @(negedge clk);
        chk("reset_no_strobe", 64'({imem_we, reg_we}), 64'd0);
        step();
        n_reset = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", 64'(net_if.net_ready_o), 64'd1);
        chk("post_reset_empty", 64'({imem_we, reg_we}), 64'd0);
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/net_cmd_ingress.md
NET_CMD_INGRESS -- requirements
Module: net_cmd_ingress

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Clock: clk, input, 1, rising-edge clock for all state.
REQ-003 Reset: n_reset, input, 1; one clock, reset is asynchronous and active-low.
REQ-004 net_valid_i, input, 1: network packet present this cycle.
REQ-005 net_cmd_i, input, 3: command code (net_cmd_e).
REQ-006 net_addr_i, input, 10: IMEM or register-file address.
REQ-007 net_data_i, input, 32: write data, or the PC value for PC commands.
REQ-008 net_parity_i, input, 1: even parity over cmd, addr and data; used only under the macro in REQ-025.
REQ-009 net_ready_o, output, 1: packet accepted at the edge where net_valid_i and net_ready_o are both 1.
REQ-010 state_i, input, state_e: current core state (RUN, IDLE or ERR).
REQ-011 stall_i, input, 1: pipeline stall; blocks issue.
REQ-012 imem_we_o, output, 1: instruction-memory write strobe.
REQ-013 reg_we_o, output, 1: register-file write strobe.
REQ-014 addr_o, output, 10 and data_o, output, 32: write address and write data for the strobes.
REQ-015 pc_we_o, output, 1: PC load strobe; the PC value is on data_o.
REQ-016 net_PC_write_cmd_IDLE_o, output, 1: single-cycle pulse that releases the core from IDLE to RUN.
REQ-017 drop_cnt_o, output, 8: count of dropped packets.

Function
REQ-018 Command codes: NOP=0, IMEM_WR=1, REG_WR=2, PC_WR=3, PC_WR_RUN=4; codes 5-7 are illegal.
REQ-019 Acceptance:
- net_ready_o = ~full; it has no combinational dependence on issue.
- Accepted legal packets are enqueued in arrival order.
- Illegal codes are not enqueued; drop_cnt_o increments instead.
REQ-020 Issue condition: FIFO non-empty, ~stall_i, and state_i != RUN.
- When the condition holds, the head entry drives the outputs combinationally in the same cycle.
- The head is dequeued at the next edge.
- At most one entry issues per cycle.
REQ-021 Per-command outputs on issue:
- IMEM_WR: imem_we_o=1.
- REG_WR: reg_we_o=1.
- PC_WR: pc_we_o=1.
- PC_WR_RUN: pc_we_o=1, plus net_PC_write_cmd_IDLE_o=1 only if state_i==IDLE; in ERR, only pc_we_o is driven.
- NOP: dequeued with no strobe.
REQ-022 Latency: a packet accepted at edge N into an empty FIFO, with the issue condition true in cycle N+1, drives its strobe during cycle N+1.
REQ-023 Non-issue cycles: all strobes are 0, and addr_o and data_o are 0.
REQ-024 Boundaries:
- Read and write pointers wrap modulo DEPTH.
- Simultaneous enqueue and dequeue leaves the count unchanged.
- When full, net_ready_o=0 even in a cycle that dequeues.
- While state_i==RUN or stall_i=1, the head is held and entries are not lost.
- drop_cnt_o saturates at 255.

Configuration
REQ-025 Macro NET_CMD_PARITY_EN:
- Defined: an accepted packet with a parity mismatch is not enqueued and increments drop_cnt_o.
- Undefined: net_parity_i is ignored and only illegal codes are dropped.

Reset
REQ-026 While n_reset=0, every output SHALL be 0, including net_ready_o.
REQ-027 Reset SHALL empty the FIFO and clear drop_cnt_o; net_ready_o is 1 in the first cycle after release.
REQ-028 A reset asserted mid-operation SHALL discard queued entries; no strobe occurs while n_reset=0.

Structure
REQ-029 The shared definitions package SHALL hold net_cmd_e, the packed entry struct (cmd, addr, data), and the DEPTH default; state_e is reused from the same package.
REQ-030 The FIFO SHALL be a sub-module, net_cmd_fifo (parameterised DEPTH, valid/ready push, pop strobe, full/empty flags); decode and issue logic live in net_cmd_ingress.

Verification
REQ-031 IMEM write: state_i=IDLE, send IMEM_WR addr=0x010 data=0xDEADBEEF -> next cycle imem_we_o=1, addr_o=0x010, data_o=0xDEADBEEF, other strobes 0.
REQ-032 Hold while running: state_i=RUN, send 4 REG_WR packets -> net_ready_o=0 after the 4th, no strobes; switch to IDLE -> 4 reg_we_o pulses on consecutive cycles, in order.
REQ-033 PC release: state_i=IDLE, send PC_WR_RUN data=0x00000040 -> pc_we_o=1 and net_PC_write_cmd_IDLE_o=1 for exactly one cycle, data_o=0x40; repeat in ERR -> pc_we_o=1 and pulse 0.
REQ-034 Drops: send code 6 three times, plus (with NET_CMD_PARITY_EN) one packet with bad parity -> drop_cnt_o=4 and no strobes; 300 drops -> drop_cnt_o=255.
REQ-035 Stall and reset: IDLE with stall_i=1 and 2 entries queued -> no issue; assert n_reset mid-stream -> outputs 0 immediately, FIFO empty after release, net_ready_o=1.
